aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand.sv | 110 +++++++++++
 tb/tb_aes_key_expand.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encodings and the key-schedule round constant table.
// Imported by the key expander and the Crypto core.
package aes_pkg;

    localparam int NB      = 4;
    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int ROUND_W = 128;
    localparam int SCHED_W = 1408;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef logic [31:0] word_t;

    // Rcon[round] is x^(round-1) in GF(2^8); round 0 and anything past 10 are unused.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; byte_out = S(byte_in).
// Shared between the key expander and the Crypto encrypt datapath.
module aes_sbox (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    // Entry 0x00 occupies the top byte, so the lookup offset is (255 - byte_in) * 8.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_out = SBOX_TBL[{~byte_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock after a start pulse,
// full 11-round schedule (round 0 in the MSBs) presented with a one-cycle done pulse.
module aes_key_expand #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [127:0]             i_Key,
    input  logic                     i_fStart,
    output logic [128*(NR+1)-1:0]    o_Key,
    output logic                     o_fBusy,
    output logic                     o_fDone
);

    import aes_pkg::*;

    localparam int         KEY_W      = 32 * NK;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0]               state_r;
    logic [3:0]               round_r;
    logic [KEY_W-1:0]         w_r;
    logic [128*(NR+1)-1:0]    key_r;
    logic                     busy_r;
    logic                     done_r;

    word_t                    rot_s;
    word_t                    sub_s;
    word_t                    temp_s;
    word_t                    n0_s;
    word_t                    n1_s;
    word_t                    n2_s;
    word_t                    n3_s;
    logic [KEY_W-1:0]         next_s;

    // SubWord: one S-box per byte of the rotated last word.
    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .byte_in  (rot_s[8*b +: 8]),
            .byte_out (sub_s[8*b +: 8])
        );
    end

    // Next-round words from the current working words (w0 is the MSB word).
    always_comb begin
        rot_s  = {w_r[23:0], w_r[31:24]};
        temp_s = sub_s ^ {rcon(round_r), 24'h000000};
        n0_s   = w_r[127:96] ^ temp_s;
        n1_s   = w_r[95:64]  ^ n0_s;
        n2_s   = w_r[63:32]  ^ n1_s;
        n3_s   = w_r[31:0]   ^ n2_s;
        next_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // Control FSM and schedule storage; starts are honoured only from IDLE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            round_r <= 4'd0;
            w_r     <= '0;
            key_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_fStart) begin
                        key_r   <= {i_Key, {(128*NR){1'b0}}};
                        w_r     <= i_Key;
                        round_r <= 4'd1;
                        state_r <= ST_EXPAND;
                        busy_r  <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (round_r == 4'(i)) begin
                            key_r[(NR-i)*ROUND_W +: ROUND_W] <= next_s;
                        end
                    end
                    w_r <= next_s;
                    if (round_r == LAST_ROUND) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    round_r <= 4'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    round_r <= 4'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Key   = key_r;
    assign o_fBusy = busy_r;
    assign o_fDone = done_r;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: known-answer round keys queued at start,
// checked when the schedule completes, plus busy/done timing and abort cases.
module tb_aes_key_expand;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [127:0]   i_Key;
    logic           i_fStart;
    logic [1407:0]  o_Key;
    logic           o_fBusy;
    logic           o_fDone;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2      = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] KEY2_R1   = 128'he232fcf191129188b159e4e6d679a293;
    localparam logic [127:0] KEY2_R10  = 128'h28fddef86da4244accc0a4fe3b316f26;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int             n_vec = 0;
    int             n_err = 0;
    logic [127:0]   exp_q[$];
    int             slice_q[$];
    int             pulses;
    int             first_j;
    int             last_j;
    int             busy_cyc;
    logic [1407:0]  snap;

    always #5 Clk = ~Clk;

    aes_key_expand dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_Key    (i_Key),
        .i_fStart (i_fStart),
        .o_Key    (o_Key),
        .o_fBusy  (o_fBusy),
        .o_fDone  (o_fDone)
    );

    function automatic logic [127:0] slice_of(input int r);
        return o_Key[(10-r)*128 +: 128];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int r, input logic [127:0] v);
        slice_q.push_back(r);
        exp_q.push_back(v);
    endtask

    task automatic push_set(input logic [127:0] k, input logic [127:0] r1, input logic [127:0] r10);
        push_exp(0, k);
        push_exp(1, r1);
        push_exp(10, r10);
    endtask

    task automatic drain(input string tag);
        while (slice_q.size() > 0) begin
            int           r;
            logic [127:0] e;
            r = slice_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s_round%0d", tag, r), slice_of(r), e);
        end
    endtask

    task automatic start(input logic [127:0] k);
        @(negedge Clk);
        i_Key    = k;
        i_fStart = 1'b1;
    endtask

    // Observe `cycles` negedges after the start edge; start stays high for `hold` edges.
    task automatic watch(input int cycles, input int hold);
        pulses   = 0;
        first_j  = -1;
        last_j   = -1;
        busy_cyc = 0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge Clk);
            if (j >= hold - 1) i_fStart = 1'b0;
            if (o_fBusy) busy_cyc++;
            if (o_fDone) begin
                if (pulses == 0) begin
                    first_j = j;
                    snap    = o_Key;
                end
                last_j = j;
                pulses++;
            end
        end
    endtask

    initial begin
        Rst      = 1'b1;
        i_Key    = '0;
        i_fStart = 1'b0;
        repeat (2) @(negedge Clk);
        check_int("reset_key_zero", int'(|o_Key), 0);
        check_int("reset_busy", int'(o_fBusy), 0);
        check_int("reset_done", int'(o_fDone), 0);
        Rst = 1'b0;

        // FIPS-197 key, single-cycle start
        push_set(FIPS_KEY, FIPS_R1, FIPS_R10);
        start(FIPS_KEY);
        watch(14, 1);
        check_int("fips_done_pulses", pulses, 1);
        check_int("fips_done_cycle", first_j, 10);
        check_int("fips_busy_cycles", busy_cyc, 10);
        drain("fips");

        // Second known-answer key
        push_set(KEY2, KEY2_R1, KEY2_R10);
        start(KEY2);
        watch(14, 1);
        check_int("key2_done_pulses", pulses, 1);
        drain("key2");

        // Starts with a zero key during expansion must be ignored
        push_set(FIPS_KEY, FIPS_R1, FIPS_R10);
        start(FIPS_KEY);
        pulses = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge Clk);
            if (o_fDone) pulses++;
            if (j == 3 || j == 9) begin
                i_Key    = '0;
                i_fStart = 1'b1;
            end else begin
                i_fStart = 1'b0;
            end
        end
        check_int("ignored_start_done_pulses", pulses, 1);
        drain("ignored_start");

        push_set(128'h0, ZERO_R1, ZERO_R10);
        start(128'h0);
        watch(14, 1);
        check_int("zero_done_pulses", pulses, 1);
        drain("zero");

        // Asynchronous reset in the middle of round 5
        start(FIPS_KEY);
        for (int j = 0; j < 5; j++) begin
            @(negedge Clk);
            i_fStart = 1'b0;
        end
        #2 Rst = 1'b1;
        #1;
        check_int("abort_key_zero", int'(|o_Key), 0);
        check_int("abort_busy", int'(o_fBusy), 0);
        check_int("abort_done", int'(o_fDone), 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        watch(15, 1);
        check_int("abort_no_done", pulses, 0);
        check_int("abort_no_busy", busy_cyc, 0);
        push_set(FIPS_KEY, FIPS_R1, FIPS_R10);
        start(FIPS_KEY);
        watch(14, 1);
        check_int("restart_done_pulses", pulses, 1);
        drain("restart");

        // Start held for 15 cycles: two back-to-back expansions
        push_set(FIPS_KEY, FIPS_R1, FIPS_R10);
        start(FIPS_KEY);
        watch(30, 15);
        check_int("held_done_pulses", pulses, 2);
        check_int("held_first_done", first_j, 10);
        check_int("held_second_done", last_j, 22);
        check_int("held_busy_cycles", busy_cyc, 20);
        check_int("held_runs_identical", int'(|(snap ^ o_Key)), 0);
        drain("held");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
